// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the word-organised data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority per M0_PRIO.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000,
    parameter bit          M0_PRIO    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [3:0]  m0_req_strb,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [3:0]  m1_req_strb,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic        dmem_wr_en,
    output logic [31:0] dmem_bit_wr_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wr_data,
    input  logic [31:0] dmem_rd_data
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic            rsp_owner_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;

    logic            owner_ready_c;
    logic            accept_c;
    logic            grant_c;
    logic            prefer_m1_c;
    logic            win_c;
    logic            sel_we_c;
    logic [DW-1:0]   sel_addr_c;
    logic [SW-1:0]   sel_strb_c;
    logic [DW-1:0]   sel_wdata_c;
    logic            in_range_c;

`ifdef DMEM_ARB_RR_EN
    logic            last_grant_q;
`endif

    // Tie-break preference: round-robin favours the port not granted last.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        prefer_m1_c = (last_grant_q == 1'b0);
`else
        prefer_m1_c = !M0_PRIO;
`endif
    end

    // Arbitration, memory drive and next-state decode.
    always_comb begin
        state_d        = state_q;
        m0_req_ready   = 1'b0;
        m1_req_ready   = 1'b0;
        dmem_wr_en     = 1'b0;
        dmem_bit_wr_en = '0;
        dmem_addr      = '0;
        dmem_wr_data   = '0;

        owner_ready_c = rsp_owner_q ? m1_rsp_ready : m0_rsp_ready;
        accept_c      = !rst && ((state_q == IDLE) || owner_ready_c);
        win_c         = (m0_req_valid && m1_req_valid) ? prefer_m1_c : m1_req_valid;
        grant_c       = accept_c && (m0_req_valid || m1_req_valid);

        sel_we_c    = win_c ? m1_req_we    : m0_req_we;
        sel_addr_c  = win_c ? m1_req_addr  : m0_req_addr;
        sel_strb_c  = win_c ? m1_req_strb  : m0_req_strb;
        sel_wdata_c = win_c ? m1_req_wdata : m0_req_wdata;
        in_range_c  = (sel_addr_c < ADDR_LIMIT);

        if (grant_c) begin
            m0_req_ready   = !win_c;
            m1_req_ready   = win_c;
            dmem_addr      = sel_addr_c;
            dmem_wr_data   = sel_wdata_c;
            dmem_bit_wr_en = {{8{sel_strb_c[3]}}, {8{sel_strb_c[2]}},
                              {8{sel_strb_c[1]}}, {8{sel_strb_c[0]}}};
            dmem_wr_en     = sel_we_c && (sel_strb_c != '0) && in_range_c;
            state_d        = RESP;
        end else if ((state_q == RESP) && owner_ready_c) begin
            state_d = IDLE;
        end
    end

    // Response registers; a pending response is dropped by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_owner_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                rsp_owner_q <= win_c;
                rsp_rdata_q <= (!sel_we_c && in_range_c) ? dmem_rd_data : DW'(0);
                rsp_err_q   <= !in_range_c;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (grant_c) begin
            last_grant_q <= win_c;
        end
    end
`endif

    assign m0_rsp_valid = (state_q == RESP) && (rsp_owner_q == 1'b0);
    assign m1_rsp_valid = (state_q == RESP) && (rsp_owner_q == 1'b1);
    assign m0_rsp_rdata = rsp_rdata_q;
    assign m1_rsp_rdata = rsp_rdata_q;
    assign m0_rsp_err   = rsp_err_q;
    assign m1_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64 KiB data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_strb;
    logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_strb;
    logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        dmem_wr_en;
    logic [31:0] dmem_bit_wr_en, dmem_addr, dmem_wr_data, dmem_rd_data;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_strb(m0_req_strb), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_strb(m1_req_strb), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .dmem_wr_en(dmem_wr_en), .dmem_bit_wr_en(dmem_bit_wr_en), .dmem_addr(dmem_addr),
        .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data)
    );

    // Memory: combinational read, bit-masked synchronous write.
    logic [31:0] mem [0:16383];
    assign dmem_rd_data = mem[dmem_addr[15:2]];
    always @(posedge clk)
        if (dmem_wr_en)
            mem[dmem_addr[15:2]] <= (mem[dmem_addr[15:2]] & ~dmem_bit_wr_en) | (dmem_wr_data & dmem_bit_wr_en);

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    bit          grant_q[$];
    logic [31:0] model [0:16383];
    logic [31:0] last_bwe;
    bit          wr_seen;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model update and expected-response push on each accepted request.
    task automatic on_accept(input bit p, input bit we, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [31:0] wd);
        exp_t        e;
        bit          in_r;
        logic [31:0] m;
        in_r    = (addr < 32'h0001_0000);
        e.port  = p;
        e.err   = !in_r;
        e.rdata = (!we && in_r) ? model[addr[15:2]] : 32'h0;
        sb_q.push_back(e);
        grant_q.push_back(p);
        check("acc_addr", dmem_addr, addr);
        check("acc_wr_en", 32'(dmem_wr_en), 32'(we && (strb != 4'h0) && in_r));
        last_bwe = dmem_bit_wr_en;
        if (we && in_r) begin
            m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            model[addr[15:2]] = (model[addr[15:2]] & ~m) | (wd & m);
        end
    endtask

    task automatic pop_check(input bit p, input logic [31:0] rdata, input bit err);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_rsp", 32'(p), 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            check("rsp_port", 32'(p), 32'(e.port));
            check("rsp_rdata", rdata, e.rdata);
            check("rsp_err", 32'(err), 32'(e.err));
        end
    endtask

    // Monitor: handshakes sampled mid-cycle, taking effect at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_wr_en) wr_seen = 1'b1;
            if (m0_req_ready || m1_req_ready)
                check("one_grant", 32'(m0_req_ready && m1_req_ready), 32'h0);
            if (m0_rsp_valid && m0_rsp_ready) pop_check(1'b0, m0_rsp_rdata, m0_rsp_err);
            if (m1_rsp_valid && m1_rsp_ready) pop_check(1'b1, m1_rsp_rdata, m1_rsp_err);
            if (m0_req_valid && m0_req_ready)
                on_accept(1'b0, m0_req_we, m0_req_addr, m0_req_strb, m0_req_wdata);
            else if (m1_req_valid && m1_req_ready)
                on_accept(1'b1, m1_req_we, m1_req_addr, m1_req_strb, m1_req_wdata);
        end
    end

    task automatic issue(input bit p, input bit we, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wd);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        if (p) begin
            m1_req_we = we; m1_req_addr = addr; m1_req_strb = strb; m1_req_wdata = wd; m1_req_valid = 1'b1;
        end else begin
            m0_req_we = we; m0_req_addr = addr; m0_req_strb = strb; m0_req_wdata = wd; m0_req_valid = 1'b1;
        end
        while (!got && n < 20) begin
            @(negedge clk);
            got = p ? m1_req_ready : m0_req_ready;
            n++;
        end
        check("accept_timeout", 32'(got), 32'h1);
        @(posedge clk); #1;
        if (p) m1_req_valid = 1'b0; else m0_req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]   = 32'h0;
            model[i] = 32'h0;
        end
        rst = 1'b1;
        wr_seen = 1'b0;
        last_bwe = 32'h0;
        m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 32'h0; m0_req_strb = 4'hF; m0_req_wdata = 32'h0;
        m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = 32'h0; m1_req_strb = 4'h0; m1_req_wdata = 32'h0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;

        // Reset state with a request pending.
        repeat (2) @(negedge clk);
        check("rst_m0_req_ready", 32'(m0_req_ready), 32'h0);
        check("rst_wr_en", 32'(dmem_wr_en), 32'h0);
        check("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'h0);
        check("rst_m1_rsp_valid", 32'(m1_rsp_valid), 32'h0);
        check("rst_rdata", m0_rsp_rdata, 32'h0);
        check("rst_err", 32'(m0_rsp_err), 32'h0);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        rst = 1'b0;

        // Full store then load, one-cycle latency.
        issue(1'b0, 1'b1, 32'h100, 4'hF, 32'hAABBCCDD);
        issue(1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        check("lat_valid", 32'(m0_rsp_valid), 32'h1);
        check("lat_rdata", m0_rsp_rdata, 32'hAABBCCDD);
        check("lat_err", 32'(m0_rsp_err), 32'h0);
        @(posedge clk); #1;
        check("lat_pop", 32'(m0_rsp_valid), 32'h0);

        // Partial store via byte strobes.
        issue(1'b0, 1'b1, 32'h104, 4'hF, 32'h11223344);
        issue(1'b0, 1'b1, 32'h104, 4'b0101, 32'hFFFFFFFF);
        check("strb_bwe", last_bwe, 32'h00FF00FF);
        issue(1'b0, 1'b0, 32'h104, 4'h0, 32'h0);
        check("strb_rdata", m0_rsp_rdata, 32'h11FF33FF);

        // Store with empty strobe: no write, normal ack.
        issue(1'b1, 1'b1, 32'h104, 4'h0, 32'hDEADBEEF);
        check("strb0_err", 32'(m1_rsp_err), 32'h0);

        // Out-of-range accesses.
        @(posedge clk); #1;
        wr_seen = 1'b0;
        issue(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        check("oor_ld_err", 32'(m1_rsp_err), 32'h1);
        check("oor_ld_rdata", m1_rsp_rdata, 32'h0);
        issue(1'b1, 1'b1, 32'h0001_0004, 4'hF, 32'h55555555);
        check("oor_st_err", 32'(m1_rsp_err), 32'h1);
        @(posedge clk); #1;
        check("oor_no_write", 32'(wr_seen), 32'h0);

        // Backpressure and drain-and-accept.
        m0_rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        m1_req_we = 1'b0; m1_req_addr = 32'h104; m1_req_strb = 4'h0; m1_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_m0_ready", 32'(m0_req_ready), 32'h0);
            check("bp_m1_ready", 32'(m1_req_ready), 32'h0);
            check("bp_valid", 32'(m0_rsp_valid), 32'h1);
            check("bp_rdata", m0_rsp_rdata, 32'hAABBCCDD);
        end
        @(posedge clk); #1;
        m0_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_accept", 32'(m1_req_ready), 32'h1);
        check("bp_drain_valid", 32'(m0_rsp_valid), 32'h1);
        @(posedge clk); #1;
        m1_req_valid = 1'b0;
        check("bp_m1_valid", 32'(m1_rsp_valid), 32'h1);
        check("bp_m1_rdata", m1_rsp_rdata, 32'h11FF33FF);
        @(posedge clk); #1;

        // Asynchronous reset while a response is held.
        m0_rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 32'h104, 4'h0, 32'h0);
        check("pre_rst_valid", 32'(m0_rsp_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(m0_rsp_valid), 32'h0);
        sb_q.delete();
        m0_rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Contention: both valid for four accepts after reset release.
        grant_q.delete();
        rst = 1'b0;
        m0_req_we = 1'b0; m0_req_addr = 32'h100; m0_req_valid = 1'b1;
        m1_req_we = 1'b0; m1_req_addr = 32'h104; m1_req_valid = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        check("tie_count", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            bit g;
            bit exp_g;
            g = (i < grant_q.size()) ? grant_q[i] : 1'bx;
`ifdef DMEM_ARB_RR_EN
            exp_g = (i % 2) == 1;
`else
            exp_g = 1'b0;
`endif
            check("tie_grant", 32'(g), 32'(exp_g));
        end

        // Drain remaining responses.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-organised data memory (64 KiB, combinational read, masked synchronous write).
- Port m0 is the core load/store unit; port m1 is the DMA/debug master.
- Grants at most one access per cycle, expands byte strobes into the memory's per-bit write mask, and returns a registered response with valid/ready backpressure.
- One transaction is outstanding at a time.

Parameters:
- ADDR_LIMIT, 32'h0001_0000, first byte address outside the memory; accesses at or above it return an error.
- M0_PRIO, 1, fixed-priority mode only: 1 means m0 wins ties, 0 means m1 wins ties.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid (N = 0, 1; applies to all mN_ lines)
- mN_req_ready  out  1  request accepted this cycle when valid && ready
- mN_req_we  in  1  1 = store, 0 = load
- mN_req_addr  in  32  byte address; bits [1:0] ignored
- mN_req_strb  in  4  byte write strobes; ignored for loads
- mN_req_wdata  in  32  store data
- mN_rsp_valid  out  1  response valid
- mN_rsp_ready  in  1  response consumed
- mN_rsp_rdata  out  32  load data; 0 for stores and errors
- mN_rsp_err  out  1  address >= ADDR_LIMIT
- dmem_wr_en  out  1  to memory wr_en
- dmem_bit_wr_en  out  32  to memory bit_wr_en
- dmem_addr  out  32  to memory addr
- dmem_wr_data  out  32  to memory wr_data
- dmem_rd_data  in  32  from memory rd_data

Behaviour:
- States:
  - IDLE: no response pending.
  - RESP: a response is held for the granted port (rsp_owner).
- Accept condition: state == IDLE, or RESP with the owner's rsp_ready high (drain-and-accept in the same cycle).
- Request ready:
  - When the accept condition holds, req_ready = 1 only for the arbitration winner among valid requesters.
  - Otherwise both req_ready = 0.
  - req_ready never depends on the requester's own req_valid except through arbitration.
- Fixed priority (default): the winner is the valid port favoured by M0_PRIO.
- Memory drive on an accepted request (combinational, same cycle):
  - dmem_addr = req_addr.
  - dmem_wr_data = req_wdata.
  - dmem_bit_wr_en[8i+7:8i] = {8{strb[i]}}.
  - dmem_wr_en = we && (strb != 0) && (addr < ADDR_LIMIT).
  - The write commits at the next posedge.
- Memory drive when no request is accepted: all dmem_* outputs = 0, with wr_en = 0.
- Response capture at the posedge following acceptance:
  - rsp_rdata <= (!we && in range) ? dmem_rd_data : 0.
  - rsp_err <= !(addr < ADDR_LIMIT).
  - rsp_owner <= winner; state <= RESP.
  - Load latency is 1 cycle; throughput is 1 access/cycle when rsp_ready is held high.
- mN_rsp_valid = (state == RESP) && (rsp_owner == N); the other port's rsp_valid = 0.
- rdata/err are stable while valid && !ready.
- Owner pops with no new accept: state <= IDLE.
- Out-of-range stores never write memory. Out-of-range loads return rdata = 0 with err = 1.
- Store with strb = 0: no memory write, normal ack, err = 0.
- A load issued the cycle after a store to the same word returns the new data (write committed at the prior edge).
- Reset (async, any time):
  - state = IDLE; rsp_owner = 0; all rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All req_ready = 0 while rst is high; dmem_wr_en = 0.
  - A pending response is discarded.
  - Round-robin pointer = m0 preferred.

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_grant register, reset to 1, so m0 is preferred first.
  - On a tie, the port not granted last wins; last_grant updates only on accept.
  - M0_PRIO is ignored.
- Undefined: fixed priority per M0_PRIO; no last_grant register.

Test Plan:
- m0 store addr 0x100, wdata 0xAABBCCDD, strb 4'b1111, then m0 load 0x100 -> load rsp_rdata 0xAABBCCDD, err 0, rsp_valid exactly 1 cycle after accept.
- Prime 0x104 = 0x11223344, then store 0xFFFFFFFF with strb 4'b0101, then load -> rdata 0x11FF33FF; dmem_bit_wr_en observed 0x00FF00FF during the store.
- m0 and m1 both valid for 4 cycles, rsp_ready high:
  - fixed priority (M0_PRIO = 1): m0 granted 4 times, m1 starves;
  - with DMEM_ARB_RR_EN: grants alternate m0, m1, m0, m1.
- m1 load 0x0001_0000 -> rsp_err 1, rdata 0; m1 store 0x0001_0004 -> err 1, dmem_wr_en never asserted.
- Backpressure: m0 load accepted, m0_rsp_ready low for 3 cycles -> both req_ready 0, rdata stable; ready raised with m1 valid -> m1 accepted in the same cycle m0 pops.
- Assert rst while in RESP with rsp_valid high -> rsp_valid drops immediately (asynchronously); after release, the first tie grants m0 (under RR).
